addr8u_swap_check_seq: RTL
==========================

Name: addr8u_swap_check_seq

Overview:
- Sequential operand-issue and result-capture stage wrapped around one combinational 8-bit unsigned adder instance from the addr8u family.
- Accepts an operand pair over a valid/ready handshake and drives the adder's A/B pins. Then re-drives the pair with A and B swapped. Addition is commutative, so a fault-free adder returns the same 9-bit sum both times.
- Returns the first sum plus a fault flag on a valid/ready output. Keeps a saturating count of detected mismatches.

Parameters:
- SETTLE, 1, cycles each operand pair is held on the adder before its sum is sampled (>=1).
- CHECK_EN, 1, 1 = run the swapped second pass; 0 = single pass, out_fault tied 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  8  operand A, unsigned.
- in_b  input  8  operand B, unsigned.
- add_a  output  8  registered A pins to the adder.
- add_b  output  8  registered B pins to the adder.
- add_sum  input  9  adder O[8:0], combinational from add_a/add_b.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  9  first-pass sum.
- out_fault  output  1  first-pass and swapped-pass sums differ.
- fault_cnt  output  8  saturating count of delivered results with out_fault=1.
- clr_cnt  input  1  synchronous clear of fault_cnt.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, add_a=0, add_b=0, out_valid=0, out_sum=0, out_fault=0, fault_cnt=0, internal settle counter=0. in_ready=0 while rst=1.
- Reset mid-operation: the in-flight pair is dropped and no result is produced.
- FSM states: IDLE, PASS1, PASS2, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a/in_b, load add_a=in_a and add_b=in_b, clear the settle counter, go to PASS1.
- PASS1:
  - Hold add_a/add_b for SETTLE cycles.
  - On the edge ending the SETTLE-th cycle, capture add_sum into s1.
  - If CHECK_EN=1: load add_a=B, add_b=A, go to PASS2.
  - If CHECK_EN=0: go to RESP.
- PASS2:
  - Hold the swapped pair for SETTLE cycles.
  - On the last edge, capture add_sum into s2, go to RESP.
- RESP:
  - out_valid=1, out_sum=s1, out_fault=(s1!=s2) when CHECK_EN=1, else 0.
  - out_sum and out_fault remain stable until out_valid&&out_ready.
  - On that handshake: out_valid drops, add_a/add_b return to 0, go to IDLE.
- Latency: with acceptance on edge k, out_valid is visible after edge k+SETTLE*(1+CHECK_EN). With defaults this is k+2.
- Throughput: in_ready=0 in PASS1, PASS2 and RESP. A new pair is accepted no earlier than the cycle after the output handshake, so there is at least one bubble.
- Width rules: 9-bit sum, no truncation. The carry is out_sum[8]. s1 and s2 are compared on all 9 bits.
- fault_cnt:
  - Increments by 1 on each output handshake with out_fault=1.
  - Saturates at 255.
  - clr_cnt=1 forces 0 on the next edge and wins over a simultaneous increment.
- Outputs add_a/add_b are registered only, with no combinational path from in_*. out_valid/out_sum/out_fault are registered. in_ready is decoded from state and rst.

Test Plan:
- Fault-free adder model, a=0xFF, b=0x01, out_ready=1 -> out_sum=0x100, out_fault=0, out_valid exactly 2 edges after acceptance, fault_cnt=0.
- a=0x5A, b=0xA5, then a=0x00, b=0x00 back-to-back with in_valid held -> sums 0x0FF then 0x000. The second acceptance happens only after the first output handshake, with one bubble.
- Faulty adder model that forces O[0]=0 whenever A==0x03; a=0x03, b=0x10 -> s1=0x012, s2=0x013, out_sum=0x012, out_fault=1, fault_cnt=1.
- out_ready low 5 cycles in RESP -> out_valid stays 1, out_sum/out_fault stable, in_ready=0, in_valid pulses ignored. Handshake on release, then IDLE.
- rst asserted during PASS2 -> next edge: add_a=add_b=0, out_valid=0, fault_cnt=0. No result is emitted, and in_ready=1 after rst deasserts.
- 257 faulty transactions -> fault_cnt=255 held. Then clr_cnt=1 on the same edge as a faulty handshake -> fault_cnt=0. Separately, CHECK_EN=0, SETTLE=3 -> latency 3 edges, out_fault=0 even with the faulty adder.

Source files
------------

// File: rtl/addr8u_swap_check_seq.sv
// Operand-issue / result-capture stage around one combinational 8-bit unsigned adder.
// Each operand pair is applied to the adder and then, when CHECK_EN is set, applied
// again with A and B swapped. A fault-free adder is commutative, so the two 9-bit sums
// must match. A mismatch is reported with the result and counted in a saturating counter.
module addr8u_swap_check_seq #(
    parameter int unsigned SETTLE   = 1,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [8:0] add_sum,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_sum,
    output logic       out_fault,
    output logic [7:0] fault_cnt,
    input  logic       clr_cnt
);

    // The settle counter counts 0 .. SETTLE-1 inside each pass.
    localparam int unsigned     CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPass1,
        StPass2,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      add_a_q, add_a_d;
    logic [7:0]      add_b_q, add_b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [8:0]      out_sum_q, out_sum_d;
    logic            out_fault_q, out_fault_d;
    logic [7:0]      fault_cnt_q, fault_cnt_d;

    logic settle_done;
    logic out_hs;

    assign settle_done = (cnt_q == CntLast);
    assign out_hs      = out_valid_q && out_ready;

    // Next-state for the issue/capture FSM and its registered outputs.
    // out_sum_q doubles as the first-pass sum s1: it is loaded at the end of PASS1 and
    // held through PASS2, where it is compared against the swapped-pass sum s2.
    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_fault_d = out_fault_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    add_a_d = in_a;
                    add_b_d = in_b;
                    cnt_d   = '0;
                    state_d = StPass1;
                end
            end

            StPass1: begin
                if (settle_done) begin
                    out_sum_d = add_sum;
                    cnt_d     = '0;
                    if (CHECK_EN) begin
                        // Re-issue the same pair with the operands exchanged.
                        add_a_d = add_b_q;
                        add_b_d = add_a_q;
                        state_d = StPass2;
                    end else begin
                        out_fault_d = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = StResp;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StPass2: begin
                if (settle_done) begin
                    // Full 9-bit compare so a faulty carry is also caught.
                    out_fault_d = (out_sum_q != add_sum);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StResp: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    add_a_d     = '0;
                    add_b_d     = '0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating fault counter; a clear takes priority over a same-edge increment.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (clr_cnt) begin
            fault_cnt_d = '0;
        end else if (out_hs && out_fault_q && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            add_a_q     <= '0;
            add_b_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_fault_q <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_fault_q <= out_fault_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_fault = out_fault_q;
    assign fault_cnt = fault_cnt_q;

endmodule
